unit_a_seq: RTL and testbench

UNIT_A_SEQ -- requirements
Module: unit_a_seq

---
 rtl/unit_a_seq_pkg.sv | 22 ++
 rtl/unit_a_seq_if.sv | 31 +++
 rtl/unit_a_seq_core.sv | 21 ++
 rtl/unit_a_seq.sv | 134 +++++++++++++
 tb/tb_unit_a_seq.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/unit_a_seq_pkg.sv
// Shared definitions for the unit_a sequential ALU: op codes, output-slot states, default width.
package unit_a_pkg;

  localparam int unsigned DEFAULT_WIDTH = 32;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_NEG = 3'b010,
    OP_INC = 3'b011,
    OP_ADC = 3'b100,
    OP_SBB = 3'b101,
    OP_ACC = 3'b110,
    OP_CLR = 3'b111
  } op_e;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_e;

endpackage

// File: rtl/unit_a_seq_if.sv
// Operand/result handshake bundle for unit_a_seq; slave is the ALU side, master the producer/consumer side.
interface unit_a_seq_if #(
  parameter int unsigned WIDTH = unit_a_pkg::DEFAULT_WIDTH
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [2:0]       op;
  logic             clr_sticky;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] S;
  logic             c_out;
  logic             O;
  logic             Z;
  logic             N;
  logic             sticky_ov;

  modport slave (
    input  in_valid, A, B, op, clr_sticky, out_ready,
    output in_ready, out_valid, S, c_out, O, Z, N, sticky_ov
  );

  modport master (
    output in_valid, A, B, op, clr_sticky, out_ready,
    input  in_ready, out_valid, S, c_out, O, Z, N, sticky_ov
  );

endinterface

// File: rtl/unit_a_seq_core.sv
// Combinational WIDTH-bit adder: sum = a + b_inv + cin, with carry-out and signed overflow.
module unit_a_core
  import unit_a_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b_inv,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  always_comb begin
    {cout, sum} = {1'b0, a} + {1'b0, b_inv} + {{WIDTH{1'b0}}, cin};
    // Overflow: both adder inputs share a sign the result does not.
    ovf = (a[WIDTH-1] == b_inv[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
  end

endmodule

// File: rtl/unit_a_seq.sv
// Single-stage sequential ALU: operand muxing, carry/accumulator/sticky state and a valid/ready output slot.
module unit_a_seq
  import unit_a_pkg::*;
#(
  parameter int unsigned WIDTH     = DEFAULT_WIDTH,
  parameter bit          STICKY_EN = 1'b1
) (
  input logic         clk,
  input logic         rst,
  unit_a_seq_if.slave bus
);

  op_e              op;
  logic             in_ready;
  logic             accept;
  logic             xfer;

  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic             add_cin;
  logic [WIDTH-1:0] add_sum;
  logic             add_cout;
  logic             add_ovf;
  logic             res_ovf;

  slot_e            slot_q, slot_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             c_q, c_d;
  logic             o_q, o_d;
  logic             cf_q, cf_d;
  logic             sticky_q, sticky_d;

  assign op       = op_e'(bus.op);
  assign in_ready = (slot_q == SLOT_EMPTY) || bus.out_ready;
  assign accept   = bus.in_valid && in_ready;
  assign xfer     = (slot_q == SLOT_FULL) && bus.out_ready;

  // Every op maps onto one adder: subtraction forms feed ~B (or ~A) with a carry-in.
  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    case (op)
      OP_ADD: begin add_a = bus.A;  add_b = bus.B;              end
      OP_SUB: begin add_a = bus.A;  add_b = ~bus.B; add_cin = 1'b1; end
      OP_NEG: begin add_a = '0;     add_b = ~bus.A; add_cin = 1'b1; end
      OP_INC: begin add_a = bus.A;  add_b = '0;     add_cin = 1'b1; end
      OP_ADC: begin add_a = bus.A;  add_b = bus.B;  add_cin = cf_q; end
      OP_SBB: begin add_a = bus.A;  add_b = ~bus.B; add_cin = cf_q; end
      OP_ACC: begin add_a = acc_q;  add_b = bus.A;              end
      OP_CLR: begin add_a = '0;     add_b = '0;                 end
    endcase
  end

  unit_a_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .a     (add_a),
    .b_inv (add_b),
    .cin   (add_cin),
    .sum   (add_sum),
    .cout  (add_cout),
    .ovf   (add_ovf)
  );

  assign res_ovf = (op != OP_CLR) && add_ovf;

  always_comb begin
    slot_d   = slot_q;
    s_d      = s_q;
    c_d      = c_q;
    o_d      = o_q;
    cf_d     = cf_q;
    acc_d    = acc_q;
    sticky_d = 1'b0;

    case (slot_q)
      SLOT_EMPTY: if (accept)          slot_d = SLOT_FULL;
      SLOT_FULL:  if (xfer && !accept) slot_d = SLOT_EMPTY;
    endcase

    if (accept) begin
      if (op == OP_CLR) begin
        s_d   = '0;
        c_d   = 1'b0;
        o_d   = 1'b0;
        cf_d  = 1'b0;
        acc_d = '0;
      end else begin
        s_d   = add_sum;
        c_d   = add_cout;
        o_d   = add_ovf;
        cf_d  = add_cout;
        if (op == OP_ACC) acc_d = add_sum;
      end
    end

    // A new overflow outranks a same-cycle clear.
    if (STICKY_EN) begin
      sticky_d = (accept && res_ovf) || (sticky_q && !bus.clr_sticky);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_q   <= SLOT_EMPTY;
      s_q      <= '0;
      c_q      <= 1'b0;
      o_q      <= 1'b0;
      cf_q     <= 1'b0;
      acc_q    <= '0;
      sticky_q <= 1'b0;
    end else begin
      slot_q   <= slot_d;
      s_q      <= s_d;
      c_q      <= c_d;
      o_q      <= o_d;
      cf_q     <= cf_d;
      acc_q    <= acc_d;
      sticky_q <= sticky_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (slot_q == SLOT_FULL);
  assign bus.S         = s_q;
  assign bus.c_out     = c_q;
  assign bus.O         = o_q;
  assign bus.Z         = (s_q == '0);
  assign bus.N         = s_q[WIDTH-1];
  assign bus.sticky_ov = sticky_q;

endmodule

// File: tb/tb_unit_a_seq.sv
// Scoreboard bench: a 32-bit and an 8-bit (sticky disabled) unit_a_seq driven by one stimulus stream.
module tb_unit_a_seq;
  import unit_a_pkg::*;

  typedef struct packed {
    logic [31:0] s;
    logic        c;
    logic        o;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic [2:0]  op = '0;
  logic        out_ready = 1'b0;
  logic        clr_sticky = 1'b0;

  int checks = 0;
  int errors = 0;

  exp_t q32[$];
  exp_t q8[$];

  longint unsigned m_cf [2];
  longint unsigned m_acc[2];
  bit              m_sticky[2];
  bit              m_valid;

  always #10 clk = ~clk;

  unit_a_seq_if #(.WIDTH(32)) b32 ();
  unit_a_seq_if #(.WIDTH(8))  b8  ();

  assign b32.in_valid   = in_valid;
  assign b32.A          = A;
  assign b32.B          = B;
  assign b32.op         = op;
  assign b32.out_ready  = out_ready;
  assign b32.clr_sticky = clr_sticky;
  assign b8.in_valid    = in_valid;
  assign b8.A           = A[7:0];
  assign b8.B           = B[7:0];
  assign b8.op          = op;
  assign b8.out_ready   = out_ready;
  assign b8.clr_sticky  = clr_sticky;

  unit_a_seq #(.WIDTH(32), .STICKY_EN(1'b1)) u_dut32 (.clk(clk), .rst(rst), .bus(b32));
  unit_a_seq #(.WIDTH(8),  .STICKY_EN(1'b0)) u_dut8  (.clk(clk), .rst(rst), .bus(b8));

  function automatic int wid(input int i);
    return (i == 0) ? 32 : 8;
  endfunction

  function automatic longint sx(input longint unsigned x, input int w);
    if (((x >> (w - 1)) & 64'd1) != 0) return longint'(x) - (longint'(1) << w);
    return longint'(x);
  endfunction

  // Reference: exact unsigned sum gives S and carry, exact signed value gives overflow.
  function automatic void model_op(input int w, input logic [2:0] opc,
                                   input longint unsigned a_in, input longint unsigned b_in,
                                   input longint unsigned cf, input longint unsigned acc,
                                   output longint unsigned s, output bit c, output bit o);
    longint unsigned mask = (64'd1 << w) - 64'd1;
    longint unsigned a = a_in & mask;
    longint unsigned b = b_in & mask;
    longint unsigned u = 0;
    longint          sv = 0;
    longint          lim = longint'(1) << (w - 1);
    case (opc)
      3'b000: begin u = a + b;                  sv = sx(a, w) + sx(b, w);                    end
      3'b001: begin u = a + (mask - b) + 1;     sv = sx(a, w) - sx(b, w);                    end
      3'b010: begin u = (mask - a) + 1;         sv = -sx(a, w);                              end
      3'b011: begin u = a + 1;                  sv = sx(a, w) + 1;                           end
      3'b100: begin u = a + b + cf;             sv = sx(a, w) + sx(b, w) + longint'(cf);     end
      3'b101: begin u = a + (mask - b) + cf;    sv = sx(a, w) - sx(b, w) - 1 + longint'(cf); end
      3'b110: begin u = acc + a;                sv = sx(acc, w) + sx(a, w);                  end
      default: begin u = 0;                     sv = 0;                                      end
    endcase
    s = u & mask;
    c = ((u >> w) & 64'd1) != 0;
    o = (sv >= lim) || (sv < -lim);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_cf[i] = 0;
      m_acc[i] = 0;
      m_sticky[i] = 1'b0;
    end
    m_valid = 1'b0;
    q32.delete();
    q8.delete();
  endtask

  // One clock of stimulus; handshake and sticky checked here, results by the monitor.
  task automatic cycle(input bit v, input logic [2:0] o_, input logic [31:0] a_, input logic [31:0] b_,
                       input bit ordy, input bit clr_);
    bit exp_rdy;
    bit acc_now;
    longint unsigned s;
    bit c, o;
    @(negedge clk);
    in_valid = v; op = o_; A = a_; B = b_; out_ready = ordy; clr_sticky = clr_;
    #1;
    exp_rdy = !m_valid || ordy;
    chk("in_ready32",  64'(b32.in_ready),  64'(exp_rdy));
    chk("in_ready8",   64'(b8.in_ready),   64'(exp_rdy));
    chk("out_valid32", 64'(b32.out_valid), 64'(m_valid));
    chk("out_valid8",  64'(b8.out_valid),  64'(m_valid));
    chk("sticky32",    64'(b32.sticky_ov), 64'(m_sticky[0]));
    chk("sticky8",     64'(b8.sticky_ov),  64'(m_sticky[1]));
    acc_now = v && exp_rdy;
    for (int i = 0; i < 2; i++) begin
      o = 1'b0;
      if (acc_now) begin
        model_op(wid(i), o_, longint'(a_), longint'(b_), m_cf[i], m_acc[i], s, c, o);
        if (i == 0) q32.push_back('{s: 32'(s), c: c, o: o});
        else        q8.push_back('{s: 32'(s), c: c, o: o});
        m_cf[i] = longint'(c);
        if (o_ == 3'b110) m_acc[i] = s;
        if (o_ == 3'b111) m_acc[i] = 0;
      end
      m_sticky[i] = (i == 0) && ((acc_now && o) || (m_sticky[i] && !clr_));
    end
    m_valid = acc_now || (m_valid && !ordy);
  endtask

  task automatic mon(input int i, input bit ov, input bit ordy, input logic [31:0] s,
                     input bit c, input bit o, input bit z, input bit n);
    exp_t  e;
    int    sz = (i == 0) ? q32.size() : q8.size();
    string nm = (i == 0) ? "w32" : "w8";
    if (!ov) return;
    if (sz == 0) begin
      checks++;
      errors++;
      $display("FAIL %s_unexpected_result: got out_valid=1 S=%0h expected no pending result", nm, s);
      return;
    end
    e = (i == 0) ? q32[0] : q8[0];
    chk({nm, "_S"},     64'(s), 64'(e.s));
    chk({nm, "_c_out"}, 64'(c), 64'(e.c));
    chk({nm, "_O"},     64'(o), 64'(e.o));
    chk({nm, "_Z"},     64'(z), 64'(e.s == 0));
    chk({nm, "_N"},     64'(n), 64'(e.s[wid(i) - 1]));
    if (ordy) begin
      if (i == 0) void'(q32.pop_front());
      else        void'(q8.pop_front());
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!rst) begin
        mon(0, b32.out_valid, out_ready, b32.S, b32.c_out, b32.O, b32.Z, b32.N);
        mon(1, b8.out_valid, out_ready, 32'(b8.S), b8.c_out, b8.O, b8.Z, b8.N);
      end
    end
  end

  task automatic check_reset_state(input string tag);
    chk({tag, "_out_valid32"}, 64'(b32.out_valid), 64'd0);
    chk({tag, "_out_valid8"},  64'(b8.out_valid),  64'd0);
    chk({tag, "_in_ready32"},  64'(b32.in_ready),  64'd1);
    chk({tag, "_S32"},         64'(b32.S),         64'd0);
    chk({tag, "_c_out32"},     64'(b32.c_out),     64'd0);
    chk({tag, "_O32"},         64'(b32.O),         64'd0);
    chk({tag, "_Z32"},         64'(b32.Z),         64'd1);
    chk({tag, "_N32"},         64'(b32.N),         64'd0);
    chk({tag, "_sticky32"},    64'(b32.sticky_ov), 64'd0);
  endtask

  task automatic reset_mid();
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0; clr_sticky = 1'b0;
    #3 rst = 1'b1;
    #1 check_reset_state("async_rst");
    model_reset();
    #2 rst = 1'b0;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h0000_007F;
      5: return 32'h0000_0080;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    model_reset();
    #5 check_reset_state("por");
    #10 rst = 1'b0;

    cycle(1, OP_ADD, 32'd6, 32'd6, 1, 0);
    cycle(1, OP_SUB, 32'd6, 32'd6, 1, 0);
    cycle(1, OP_ADD, 32'h7FFF_FFFF, 32'd1, 1, 0);
    cycle(1, OP_INC, 32'd1, 32'd0, 1, 0);
    cycle(1, OP_ADD, 32'd2, 32'd3, 1, 0);
    cycle(0, OP_ADD, 32'd0, 32'd0, 1, 1);
    cycle(1, OP_ADD, 32'h7FFF_FFFF, 32'd1, 1, 1);
    cycle(0, OP_ADD, 32'd0, 32'd0, 1, 1);
    cycle(0, OP_ADD, 32'd0, 32'd0, 1, 0);

    cycle(1, OP_ADD, 32'hFFFF_FFFF, 32'd1, 1, 0);
    cycle(1, OP_ADC, 32'd0, 32'd0, 1, 0);
    cycle(1, OP_CLR, 32'd5, 32'd5, 1, 0);
    cycle(1, OP_ADC, 32'd0, 32'd0, 1, 0);
    cycle(1, OP_ACC, 32'hF0, 32'd0, 1, 0);
    cycle(1, OP_ACC, 32'h20, 32'd0, 1, 0);
    cycle(1, OP_ACC, 32'd0, 32'd0, 1, 0);
    cycle(1, OP_NEG, 32'd0, 32'd0, 1, 0);
    cycle(1, OP_NEG, 32'h8000_0000, 32'd0, 1, 0);
    cycle(1, OP_SBB, 32'd5, 32'd7, 1, 0);
    cycle(1, OP_SBB, 32'd5, 32'd3, 1, 0);

    cycle(1, OP_ADD, 32'd1, 32'd2, 0, 0);
    for (int k = 0; k < 3; k++) cycle(1, OP_ADD, 32'd99, 32'd99, 0, 0);
    cycle(1, OP_ADD, 32'd4, 32'd5, 1, 0);
    cycle(1, OP_INC, 32'd9, 32'd0, 1, 0);
    cycle(0, OP_ADD, 32'd0, 32'd0, 1, 0);

    cycle(1, OP_ADD, 32'hFFFF_FFFF, 32'd1, 1, 0);
    cycle(1, OP_ACC, 32'd5, 32'd0, 0, 0);
    reset_mid();
    cycle(1, OP_ADC, 32'd0, 32'd0, 1, 0);
    cycle(1, OP_ACC, 32'd3, 32'd0, 1, 0);

    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 149) == 0) reset_mid();
      else cycle($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), pick(), pick(),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
    end

    for (int k = 0; k < 3; k++) cycle(0, OP_ADD, 32'd0, 32'd0, 1, 0);
    chk("drain32", 64'(q32.size()), 64'd0);
    chk("drain8",  64'(q8.size()),  64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
